// File: rtl/freq_mult_engine.sv
// Measures the ref_in period P in clk cycles, divides by multiplier M and emits one out_tick every K=P/M cycles.
// Build option FREQ_MULT_TRACK_EN: background re-measurement during COUNT, new K applied at the next reload.
module freq_mult_engine #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned MULT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adjust,
  input  logic              ref_in,
  input  logic [MULT_W-1:0] mult,
  output logic              out_tick,
  output logic              out_clk,
  output logic [CNT_W-1:0]  k_out,
  output logic              valid,
  output logic              busy,
  output logic              err
);
  localparam int unsigned DCNT_W = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, START, MEASURE, CALC, LOAD, COUNT} state_t;
  state_t state;

  logic              ref_s1, ref_s2, ref_d;
  logic              armed;
  logic [CNT_W-1:0]  pcnt, rcnt, rem, quo, dvs;
  logic [DCNT_W-1:0] dcnt;

  logic              ref_rise, q_bit, div_last;
  logic [CNT_W:0]    rem_sh, diff;
  logic [CNT_W-1:0]  rem_nx, quo_nx, k_new, m_ext, reload_k;

`ifdef FREQ_MULT_TRACK_EN
  logic              bg_div, pend;
  logic [CNT_W-1:0]  k_pend;
`endif

  // Restoring divider step: quo holds remaining dividend bits and collects quotient bits.
  always_comb begin
    ref_rise = ref_s2 & ~ref_d;
    m_ext    = (mult == '0) ? CNT_W'(1) : CNT_W'(mult);
    rem_sh   = {rem, quo[CNT_W-1]};
    diff     = rem_sh - {1'b0, dvs};
    q_bit    = ~diff[CNT_W];
    rem_nx   = q_bit ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
    quo_nx   = {quo[CNT_W-2:0], q_bit};
    k_new    = (quo_nx == '0) ? CNT_W'(1) : quo_nx;
    div_last = (dcnt == DCNT_W'(CNT_W - 1));
`ifdef FREQ_MULT_TRACK_EN
    reload_k = pend ? k_pend : k_out;
`else
    reload_k = k_out;
`endif
  end

  // ref_in synchroniser and edge flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_s1 <= 1'b0;
      ref_s2 <= 1'b0;
      ref_d  <= 1'b0;
    end else begin
      ref_s1 <= ref_in;
      ref_s2 <= ref_s1;
      ref_d  <= ref_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      pcnt     <= '0;
      rcnt     <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      dcnt     <= '0;
      k_out    <= '0;
      out_tick <= 1'b0;
      out_clk  <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef FREQ_MULT_TRACK_EN
      bg_div   <= 1'b0;
      pend     <= 1'b0;
      k_pend   <= '0;
`endif
    end else if (adjust) begin
      state    <= START;
      armed    <= 1'b0;
      pcnt     <= '0;
      out_tick <= 1'b0;
      out_clk  <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef FREQ_MULT_TRACK_EN
      bg_div   <= 1'b0;
      pend     <= 1'b0;
`endif
    end else begin
      out_tick <= 1'b0;
      case (state)
        IDLE: ;
        START: begin
          state <= MEASURE;
          busy  <= 1'b1;
          armed <= 1'b0;
          pcnt  <= '0;
        end
        // Saturation wins over a coincident edge: P would not fit in CNT_W bits.
        MEASURE: begin
          if (pcnt == CNT_MAX) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (ref_rise && !armed) begin
            armed <= 1'b1;
            pcnt  <= '0;
          end else if (ref_rise) begin
            quo   <= pcnt + CNT_W'(1);
            rem   <= '0;
            dvs   <= m_ext;
            dcnt  <= '0;
            armed <= 1'b0;
            pcnt  <= '0;
            state <= CALC;
          end else begin
            pcnt <= pcnt + CNT_W'(1);
          end
        end
        CALC: begin
          rem  <= rem_nx;
          quo  <= quo_nx;
          dcnt <= dcnt + DCNT_W'(1);
          if (div_last) begin
            k_out    <= k_new;
            rcnt     <= k_new - CNT_W'(1);
            out_tick <= 1'b1;
            out_clk  <= ~out_clk;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= LOAD;
          end
        end
        // rcnt counts down to the cycle before the next tick so spacing is exactly K.
        LOAD, COUNT: begin
          state <= COUNT;
          if (rcnt == '0) begin
            out_tick <= 1'b1;
            out_clk  <= ~out_clk;
            k_out    <= reload_k;
            rcnt     <= reload_k - CNT_W'(1);
`ifdef FREQ_MULT_TRACK_EN
            pend     <= 1'b0;
`endif
          end else begin
            rcnt <= rcnt - CNT_W'(1);
          end
`ifdef FREQ_MULT_TRACK_EN
          // Background period measurement; divider registers are free while counting.
          if (state == COUNT) begin
            if (pcnt == CNT_MAX) begin
              err   <= 1'b1;
              armed <= 1'b0;
              pcnt  <= '0;
            end else if (ref_rise) begin
              armed <= 1'b1;
              pcnt  <= '0;
              if (armed && !bg_div) begin
                quo    <= pcnt + CNT_W'(1);
                rem    <= '0;
                dvs    <= m_ext;
                dcnt   <= '0;
                bg_div <= 1'b1;
              end
            end else begin
              pcnt <= pcnt + CNT_W'(1);
            end
            if (bg_div) begin
              rem  <= rem_nx;
              quo  <= quo_nx;
              dcnt <= dcnt + DCNT_W'(1);
              if (div_last) begin
                bg_div <= 1'b0;
                k_pend <= k_new;
                pend   <= 1'b1;
              end
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_freq_mult_engine.sv
// Self-checking bench for freq_mult_engine: tick/out_clk behaviour model plus directed literal checks.
module tb_freq_mult_engine;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned MULT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n, adjust, ref_in;
  logic [MULT_W-1:0] mult;
  logic              out_tick, out_clk, valid, busy, err;
  logic [CNT_W-1:0]  k_out;

  int checks = 0;
  int errors = 0;
  int ref_period = 0;
  event ref_rose;

  // Behavioural model state: expected K, cycles since last tick, expected out_clk level.
  int   exp_k = 0;
  int   alt_k = 0;
  int   since = 0;
  logic mclk = 1'b0;
  logic pv = 1'b0;
  logic et;
  logic chk_en = 1'b0;
  logic must_valid = 1'b0;
  int   g, n;

  freq_mult_engine #(.CNT_W(CNT_W), .MULT_W(MULT_W)) dut (
    .clk(clk), .rst_n(rst_n), .adjust(adjust), .ref_in(ref_in), .mult(mult),
    .out_tick(out_tick), .out_clk(out_clk), .k_out(k_out),
    .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference generator: period read at each rising edge, all drives 1 time unit after posedge.
  initial begin
    int per;
    ref_in = 1'b0;
    @(posedge clk); #1;
    forever begin
      per = ref_period;
      if (per == 0) begin
        ref_in = 1'b0;
        @(posedge clk); #1;
      end else begin
        ref_in = 1'b1;
        -> ref_rose;
        repeat (per / 2) @(posedge clk);
        #1 ref_in = 1'b0;
        repeat (per - per / 2) @(posedge clk);
        #1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (!valid) begin
        check("idle_tick", out_tick, 0);
        check("idle_out_clk", out_clk, 0);
        if (must_valid) check("valid_held", valid, 1);
        since = 0;
        mclk  = 1'b0;
      end else begin
        check("busy_while_valid", busy, 0);
        if (!pv) begin
          et = 1'b1;
        end else begin
          since++;
          et = (since == exp_k);
          if (et && !out_tick && alt_k > exp_k) begin
            exp_k = alt_k;
            et    = 1'b0;
          end
        end
        if (et) begin
          since = 0;
          mclk  = ~mclk;
        end
        check("tick", out_tick, et);
        check("out_clk", out_clk, mclk);
        if (alt_k == 0) check("k_out", k_out, exp_k);
        else            check("k_out_range", (k_out == exp_k[CNT_W-1:0]) || (k_out == alt_k[CNT_W-1:0]), 1);
      end
    end
    pv = valid;
  end

  task automatic pulse_adjust(input int cycles);
    adjust = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 adjust = 1'b0;
  endtask

  // Align to ref, adjust for 3 cycles, then return at the drive of the capturing edge.
  task automatic run_measure(input int p, input int m, input int k);
    ref_period = p;
    mult = MULT_W'(m);
    @(ref_rose);
    pulse_adjust(3);
    check("err_cleared", err, 0);
    exp_k = k;
    @(ref_rose);
    @(ref_rose);
  endtask

  task automatic wait_valid(input int bound, input string name);
    int c = 0;
    while (!valid && c < bound) begin
      @(posedge clk); #1;
      c++;
    end
    check(name, valid, 1);
  endtask

  task automatic measure_gap(input bit use_clk, output int gap);
    int first = -1;
    logic prev, cur;
    prev = use_clk ? out_clk : 1'b0;
    gap = -1;
    for (int i = 0; i < 500 && gap < 0; i++) begin
      @(posedge clk); #1;
      cur = use_clk ? out_clk : out_tick;
      if (cur && (!use_clk || !prev)) begin
        if (first < 0) first = i;
        else gap = i - first;
      end
      prev = cur;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; adjust = 1'b0; mult = 4'd4;
    repeat (3) @(posedge clk); #1;
    check("rst_k_out", k_out, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_tick", out_tick, 0);
    check("rst_out_clk", out_clk, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // P=100, M=4: 2 sync + 1 capture + 16 divide cycles to LOAD
    run_measure(100, 4, 25);
    repeat (18) @(posedge clk); #1;
    check("calc_busy", busy, 1);
    check("calc_not_valid", valid, 0);
    @(posedge clk); #1;
    check("load_valid", valid, 1);
    check("load_tick", out_tick, 1);
    check("load_busy", busy, 0);
    check("k_out_25", k_out, 25);
    measure_gap(1'b0, g);
    check("tick_gap_25", g, 25);
    measure_gap(1'b1, g);
    check("out_clk_period_50", g, 50);

    // M=0 treated as 1
    run_measure(100, 0, 100);
    wait_valid(400, "valid_m0");
    check("k_out_100", k_out, 100);
    measure_gap(1'b0, g);
    check("tick_gap_100", g, 100);

    // P=3, M=8: quotient 0 clamps to 1
    run_measure(3, 8, 1);
    wait_valid(200, "valid_k1");
    check("k_out_1", k_out, 1);
    measure_gap(1'b0, g);
    check("tick_gap_1", g, 1);

    // ref held low: period counter saturates
    ref_period = 0;
    repeat (300) @(posedge clk); #1;
    pulse_adjust(3);
    repeat (65530) @(posedge clk); #1;
    check("no_err_early", err, 0);
    check("busy_measuring", busy, 1);
    n = 0;
    while (!err && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("err_latency", n, 7);
    check("ovf_err", err, 1);
    check("ovf_valid", valid, 0);
    check("ovf_busy", busy, 0);

    // adjust mid-COUNT
    run_measure(100, 4, 25);
    wait_valid(400, "valid_again");
    repeat (60) @(posedge clk); #1;
    pulse_adjust(1);
    check("adj_valid", valid, 0);
    check("adj_tick", out_tick, 0);
    check("adj_out_clk", out_clk, 0);
    n = 0;
    while (!busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("remeasure_busy", busy, 1);
    check("remeasure_err", err, 0);
    wait_valid(500, "valid_after_adj");
    check("k_out_25_again", k_out, 25);

    // asynchronous reset mid-CALC
    run_measure(100, 4, 25);
    repeat (10) @(posedge clk);
    #3;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_k_out", k_out, 0);
    check("arst_valid", valid, 0);
    check("arst_err", err, 0);
    check("arst_tick", out_tick, 0);
    check("arst_out_clk", out_clk, 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef FREQ_MULT_TRACK_EN
    // Tracking: P 100 -> 200 while counting, valid must stay high
    run_measure(100, 4, 25);
    wait_valid(400, "valid_track");
    repeat (30) @(posedge clk); #1;
    alt_k = 50;
    must_valid = 1'b1;
    ref_period = 200;
    repeat (1200) @(posedge clk); #1;
    check("track_k_out_50", k_out, 50);
    measure_gap(1'b0, g);
    check("track_tick_gap_50", g, 50);
    must_valid = 1'b0;
    exp_k = 50;
    alt_k = 0;
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
